// File: rtl/mul_result_collector_if.sv
// -----------------------------------------------------------------------------
// mul_result_collector_if
// Bundles the two streaming paths of the multiplier result collector:
//   - sample path : in_valid, in_a, in_b, in_d. There is no backpressure.
//   - record path : out_valid/out_ready handshake, plus the out_a, out_b and
//                   out_d fields of the mismatch record.
// Modports:
//   master : the environment side. It drives samples and consumes records.
//   slave  : the collector side. It consumes samples and produces records.
// -----------------------------------------------------------------------------
interface mul_result_collector_if #(
  parameter int DATA_PATH_BITWIDTH = 32
);
  logic                          in_valid;
  logic [DATA_PATH_BITWIDTH-1:0] in_a;
  logic [DATA_PATH_BITWIDTH-1:0] in_b;
  logic [DATA_PATH_BITWIDTH-1:0] in_d;

  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_PATH_BITWIDTH-1:0] out_a;
  logic [DATA_PATH_BITWIDTH-1:0] out_b;
  logic [DATA_PATH_BITWIDTH-1:0] out_d;

  modport master (
    output in_valid, in_a, in_b, in_d, out_ready,
    input  out_valid, out_a, out_b, out_d
  );

  modport slave (
    input  in_valid, in_a, in_b, in_d, out_ready,
    output out_valid, out_a, out_b, out_d
  );
endinterface

// File: rtl/mul_result_collector.sv
// -----------------------------------------------------------------------------
// mul_result_collector
// Checks the results of a multiplier under test. Every valid sample {a, b, d}
// is compared against a reference product. Any sample whose absolute error
// exceeds err_thresh is queued as a mismatch record for readout.
//
// Pipeline:
//   Stage 1 : registers a, b, d and the reference product exp. The reference
//             product uses the low OP_BITWIDTH bits of each operand,
//             sign-extended.
//   Stage 2 : computes |d - exp|. It then updates the counters and pushes
//             the mismatch record into the FIFO.
//
// Ports:
//   clk          : clock; all state changes on its rising edge
//   rst          : asynchronous reset, active low
//   clr          : synchronous clear of counters, FIFO, pipeline and flags
//   bus          : sample input and mismatch-record output (slave modport)
//   err_thresh   : unsigned absolute-error tolerance, sampled in stage 2
//   sample_cnt   : saturating count of samples that completed stage 2
//   mismatch_cnt : saturating count of mismatches
//   max_err      : largest |d - exp| seen since reset or clr
//                  (present only when COLLECT_MAX_ERR_EN is defined)
//   overflow     : sticky flag; set when a record is dropped because the
//                  FIFO was full
//
// Optional feature macro: COLLECT_MAX_ERR_EN
// -----------------------------------------------------------------------------
module mul_result_collector #(
  parameter int OP_BITWIDTH        = 32,
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  mul_result_collector_if.slave         bus,
  input  logic [DATA_PATH_BITWIDTH-1:0] err_thresh,
  output logic [15:0]                   sample_cnt,
  output logic [15:0]                   mismatch_cnt,
`ifdef COLLECT_MAX_ERR_EN
  output logic [DATA_PATH_BITWIDTH-1:0] max_err,
`endif
  output logic                          overflow
);

  localparam int DW = DATA_PATH_BITWIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] d;
  } record_t;

  // ---------------------------------------------------------------------------
  // Stage 1: reference product
  // ---------------------------------------------------------------------------
  logic signed [OP_BITWIDTH-1:0] a_op, b_op;
  logic signed [DW-1:0]          a_ext, b_ext;
  logic [DW-1:0]                 exp_d;

  assign a_op  = bus.in_a[OP_BITWIDTH-1:0];
  assign b_op  = bus.in_b[OP_BITWIDTH-1:0];
  // Size-casting a signed value to a wider width sign-extends it.
  assign a_ext = DW'(a_op);
  assign b_ext = DW'(b_op);
  // The low DW bits of the product do not depend on signedness.
  assign exp_d = a_ext * b_ext;

  logic          s1_valid_q;
  logic [DW-1:0] s1_a_q, s1_b_q, s1_d_q, s1_exp_q;

  // NOTE: only control state (the valid bits, pointers, counters and flags)
  // is reset. Datapath registers and the record storage are qualified by
  // valid bits or pointers, so they carry no reset.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      s1_a_q   <= bus.in_a;
      s1_b_q   <= bus.in_b;
      s1_d_q   <= bus.in_d;
      s1_exp_q <= exp_d;
    end
  end

  // NOTE: sequential state is always updated with non-blocking assignments,
  // so every flop samples the values that were present before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s1_valid_q <= 1'b0;
    else      s1_valid_q <= bus.in_valid & ~clr;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: error magnitude and mismatch decision
  // ---------------------------------------------------------------------------
  logic [DW:0] diff, abs_diff;
  logic        mismatch;

  // Both values are sign-extended by one bit, so the difference cannot wrap.
  assign diff     = {s1_d_q[DW-1], s1_d_q} - {s1_exp_q[DW-1], s1_exp_q};
  assign abs_diff = diff[DW] ? (~diff + (DW+1)'(1)) : diff;
  assign mismatch = abs_diff > {1'b0, err_thresh};

  // ---------------------------------------------------------------------------
  // Counters, FIFO pointers and overflow flag
  // ---------------------------------------------------------------------------
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic [15:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        overflow_q, overflow_d;
  logic        empty, full, pop, push;

  // The extra pointer bit tells full (MSBs differ) from empty (all bits equal).
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = ~empty & bus.out_ready;

  // NOTE: every variable gets its default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    sample_cnt_d   = sample_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    wptr_d         = wptr_q;
    rptr_d         = rptr_q;
    overflow_d     = overflow_q;
    push           = 1'b0;
    if (clr) begin
      sample_cnt_d   = '0;
      mismatch_cnt_d = '0;
      wptr_d         = '0;
      rptr_d         = '0;
      overflow_d     = 1'b0;
    end else begin
      if (s1_valid_q) begin
        if (sample_cnt_q != 16'hFFFF) sample_cnt_d = sample_cnt_q + 16'd1;
        if (mismatch) begin
          if (mismatch_cnt_q != 16'hFFFF) mismatch_cnt_d = mismatch_cnt_q + 16'd1;
          // A pop in the same cycle frees the slot that is written.
          if (!full || pop) push = 1'b1;
          else              overflow_d = 1'b1;
        end
      end
      if (push) wptr_d = wptr_q + (AW+1)'(1);
      if (pop)  rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt_q   <= '0;
      mismatch_cnt_q <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      overflow_q     <= 1'b0;
    end else begin
      sample_cnt_q   <= sample_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      overflow_q     <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Record storage
  // ---------------------------------------------------------------------------
  record_t mem [FIFO_DEPTH];
  record_t head;

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= '{a: s1_a_q, b: s1_b_q, d: s1_d_q};
  end

  assign head = mem[rptr_q[AW-1:0]];

  // The fields are forced to zero while the FIFO is empty. As a result they
  // read 0 during reset without resetting the storage itself.
  assign bus.out_valid = ~empty;
  assign bus.out_a     = empty ? '0 : head.a;
  assign bus.out_b     = empty ? '0 : head.b;
  assign bus.out_d     = empty ? '0 : head.d;

  assign sample_cnt   = sample_cnt_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign overflow     = overflow_q;

`ifdef COLLECT_MAX_ERR_EN
  // ---------------------------------------------------------------------------
  // Peak absolute error. It tracks every sample, matched or not.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] max_err_q, max_err_d;

  always_comb begin
    max_err_d = max_err_q;
    if (clr)                                               max_err_d = '0;
    else if (s1_valid_q && abs_diff[DW-1:0] > max_err_q)   max_err_d = abs_diff[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) max_err_q <= '0;
    else      max_err_q <= max_err_d;
  end

  assign max_err = max_err_q;
`endif

endmodule

// File: tb/tb_mul_result_collector.sv
// -----------------------------------------------------------------------------
// tb_mul_result_collector
// Directed bench for mul_result_collector. The main instance has
// OP_BITWIDTH=32. A second instance has OP_BITWIDTH=26 to exercise operand
// masking. Inputs change on the falling edge, and outputs are sampled on the
// falling edge. Expected values are hand-computed constants.
// The max_err section is present only when COLLECT_MAX_ERR_EN is defined.
// -----------------------------------------------------------------------------
module tb_mul_result_collector;

  logic        clk;
  logic        rst;
  logic        clr, clr26;
  logic [31:0] err_thresh, err_thresh26;
  logic [15:0] sample_cnt, mismatch_cnt, sample_cnt26, mismatch_cnt26;
  logic        overflow, overflow26;
`ifdef COLLECT_MAX_ERR_EN
  logic [31:0] max_err, max_err26;
`endif

  int checks   = 0;
  int failures = 0;

  mul_result_collector_if #(.DATA_PATH_BITWIDTH(32)) bus   ();
  mul_result_collector_if #(.DATA_PATH_BITWIDTH(32)) bus26 ();

  mul_result_collector #(
    .OP_BITWIDTH(32), .DATA_PATH_BITWIDTH(32), .FIFO_DEPTH(8)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .bus          (bus),
    .err_thresh   (err_thresh),
    .sample_cnt   (sample_cnt),
    .mismatch_cnt (mismatch_cnt),
`ifdef COLLECT_MAX_ERR_EN
    .max_err      (max_err),
`endif
    .overflow     (overflow)
  );

  mul_result_collector #(
    .OP_BITWIDTH(26), .DATA_PATH_BITWIDTH(32), .FIFO_DEPTH(8)
  ) u_dut26 (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr26),
    .bus          (bus26),
    .err_thresh   (err_thresh26),
    .sample_cnt   (sample_cnt26),
    .mismatch_cnt (mismatch_cnt26),
`ifdef COLLECT_MAX_ERR_EN
    .max_err      (max_err26),
`endif
    .overflow     (overflow26)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One sample on the main instance: valid for exactly one rising edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_d     = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; clr26 = 1'b0;
    err_thresh = '0; err_thresh26 = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_d = '0; bus.out_ready = 1'b0;
    bus26.in_valid = 1'b0; bus26.in_a = '0; bus26.in_b = '0; bus26.in_d = '0;
    bus26.out_ready = 1'b0;

    // ---- reset state ----
    tick(); tick();
    check("rst_sample_cnt",   32'(sample_cnt),   32'd0);
    check("rst_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    check("rst_out_valid",    32'(bus.out_valid), 32'd0);
    check("rst_overflow",     32'(overflow),     32'd0);
    check("rst_out_a",        bus.out_a,         32'd0);
    rst = 1'b1;
    tick();

    // ---- exact match: 3 * -5 = -15, two-cycle latency ----
    err_thresh = 32'd0;
    send(32'd3, -32'sd5, -32'sd15);
    check("exact_latency_cnt", 32'(sample_cnt), 32'd0);
    tick();
    check("exact_sample_cnt",   32'(sample_cnt),    32'd1);
    check("exact_mismatch_cnt", 32'(mismatch_cnt),  32'd0);
    check("exact_out_valid",    32'(bus.out_valid), 32'd0);

    // ---- tolerance boundary: 7*7=49, threshold 2 ----
    err_thresh = 32'd2;
    send(32'd7, 32'd7, 32'd51);
    tick();
    check("tol_diff2_mismatch", 32'(mismatch_cnt), 32'd0);
    check("tol_diff2_sample",   32'(sample_cnt),   32'd2);
    send(32'd7, 32'd7, 32'd52);
    tick();
    check("tol_diff3_mismatch", 32'(mismatch_cnt),  32'd1);
    check("tol_head_valid",     32'(bus.out_valid), 32'd1);
    check("tol_head_a",         bus.out_a,          32'd7);
    check("tol_head_b",         bus.out_b,          32'd7);
    check("tol_head_d",         bus.out_d,          32'd52);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("tol_pop_empty", 32'(bus.out_valid), 32'd0);
    // Negative differences: -2 is within tolerance, -3 is not.
    send(32'd7, 32'd7, 32'd47);
    tick();
    check("tol_neg2_mismatch", 32'(mismatch_cnt), 32'd1);
    send(32'd7, 32'd7, 32'd46);
    tick();
    check("tol_neg3_mismatch", 32'(mismatch_cnt), 32'd2);
    check("tol_neg3_head_d",   bus.out_d,         32'd46);

    // ---- clear ----
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_sample_cnt",   32'(sample_cnt),    32'd0);
    check("clr_mismatch_cnt", 32'(mismatch_cnt),  32'd0);
    check("clr_out_valid",    32'(bus.out_valid), 32'd0);

    // ---- operand masking on the 26-bit instance ----
    // a = FC00_0001 gives a[25:0] = 1, so exp = 2.
    // a = 0200_0000 gives -2^25 after sign extension, so exp = FC00_0000.
    // The third sample has exp = 2 but d = 0400_0000, which is a mismatch.
    bus26.in_valid = 1'b1;
    bus26.in_a = 32'hFC00_0001; bus26.in_b = 32'd2; bus26.in_d = 32'd2;
    tick();
    bus26.in_a = 32'h0200_0000; bus26.in_b = 32'd2; bus26.in_d = 32'hFC00_0000;
    tick();
    bus26.in_a = 32'd1;         bus26.in_b = 32'd2; bus26.in_d = 32'h0400_0000;
    tick();
    bus26.in_valid = 1'b0;
    check("op26_mask_sample",   32'(sample_cnt26),   32'd2);
    check("op26_mask_mismatch", 32'(mismatch_cnt26), 32'd0);
    tick();
    check("op26_third_sample",   32'(sample_cnt26),   32'd3);
    check("op26_third_mismatch", 32'(mismatch_cnt26), 32'd1);
    check("op26_head_d",         bus26.out_d,         32'h0400_0000);

    // ---- FIFO full and overflow: 9 back-to-back mismatches ----
    err_thresh    = 32'd0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(32'(i + 1), 32'd2, 32'd0);
    tick();
    check("full_mismatch_cnt", 32'(mismatch_cnt),  32'd9);
    check("full_sample_cnt",   32'(sample_cnt),    32'd9);
    check("full_overflow",     32'(overflow),      32'd1);
    check("full_out_valid",    32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", 32'(bus.out_valid), 32'd1);
      check("drain_a",     bus.out_a,          32'(k + 1));
      check("drain_b",     bus.out_b,          32'd2);
      tick();
    end
    bus.out_ready = 1'b0;
    check("drain_empty",          32'(bus.out_valid), 32'd0);
    check("drain_overflow_stick", 32'(overflow),      32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_overflow", 32'(overflow), 32'd0);

    // ---- push and pop in the same cycle while full ----
    for (int i = 0; i < 8; i++) send(32'h10 + 32'(i), 32'd3, 32'd1);
    tick();
    check("sim_full_overflow", 32'(overflow), 32'd0);
    send(32'h55, 32'd1, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("sim_overflow",     32'(overflow),     32'd0);
    check("sim_mismatch_cnt", 32'(mismatch_cnt), 32'd9);
    check("sim_head_a",       bus.out_a,         32'h11);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("sim_drain_valid", 32'(bus.out_valid), 32'd1);
      check("sim_drain_a",     bus.out_a,          (k < 7) ? 32'h11 + 32'(k) : 32'h55);
      tick();
    end
    check("sim_drain_empty", 32'(bus.out_valid), 32'd0);

    // ---- push and pop in the same cycle while empty (out_ready held high) ----
    send(32'h21, 32'd1, 32'd0);
    tick();
    check("empty_push_valid", 32'(bus.out_valid), 32'd1);
    check("empty_push_a",     bus.out_a,          32'h21);
    tick();
    check("empty_push_popped", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

`ifdef COLLECT_MAX_ERR_EN
    // ---- peak error: errors 5, 1 and 9 ----
    clr = 1'b1;
    tick();
    clr = 1'b0;
    err_thresh = 32'd100;
    send(32'd1, 32'd1, 32'd6);
    send(32'd1, 32'd1, 32'd0);
    send(32'd1, 32'd1, 32'd10);
    tick();
    check("max_err_peak", max_err, 32'd9);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("max_err_clr", max_err, 32'd0);
    err_thresh = 32'd0;
`endif

    // ---- reset mid-stream ----
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) send(32'h30 + 32'(i), 32'd1, 32'd0);
    check("pre_rst_overflow", 32'(overflow),     32'd1);
    check("pre_rst_mismatch", 32'(mismatch_cnt), 32'd9);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_out_a",     bus.out_a,          32'd0);
    check("rst_mid_out_b",     bus.out_b,          32'd0);
    check("rst_mid_out_d",     bus.out_d,          32'd0);
    check("rst_mid_sample",    32'(sample_cnt),    32'd0);
    check("rst_mid_mismatch",  32'(mismatch_cnt),  32'd0);
    check("rst_mid_overflow",  32'(overflow),      32'd0);
    tick();
    // The first edge with rst high captures this matching sample (3*3=9).
    rst = 1'b1;
    send(32'd3, 32'd3, 32'd9);
    tick();
    check("post_rst_sample",    32'(sample_cnt),    32'd1);
    check("post_rst_mismatch",  32'(mismatch_cnt),  32'd0);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_result_collector.md
MUL_RESULT_COLLECTOR -- requirements
Module: mul_result_collector

Interface
REQ-001 Parameter OP_BITWIDTH, default 32: operand significant width; bits above it are ignored and the remaining bits are sign-extended.
REQ-002 Parameter DATA_PATH_BITWIDTH, default 32: width of in_a, in_b, in_d and of the expected result.
REQ-003 Parameter FIFO_DEPTH, default 8, power of two, at least 2: depth of the mismatch-record buffer.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 clr  in  1  synchronous clear of counters, FIFO and sticky flags.
REQ-007 in_valid  in  1  sample present this cycle; no backpressure, so every valid sample is accepted.
REQ-008 in_a, in_b  in  DATA_PATH_BITWIDTH  operand pair applied to the multiplier.
REQ-009 in_d  in  DATA_PATH_BITWIDTH  result produced by the multiplier for in_a and in_b.
REQ-010 err_thresh  in  DATA_PATH_BITWIDTH  unsigned absolute-error tolerance.
REQ-011 out_valid, out_ready  out/in  1  valid/ready handshake for mismatch records.
REQ-012 out_a, out_b, out_d  out  DATA_PATH_BITWIDTH  fields of the mismatch record at the FIFO head.
REQ-013 sample_cnt, mismatch_cnt  out  16  saturating counters.
REQ-014 overflow  out  1  sticky flag: a mismatch record was dropped because the FIFO was full.

Function
REQ-015 Stage 1, on a cycle with in_valid=1: register a, b, d and exp.
- exp = sext(a[OP_BITWIDTH-1:0]) * sext(b[OP_BITWIDTH-1:0]), truncated to the low DATA_PATH_BITWIDTH bits.
REQ-016 Stage 2, one cycle after stage 1:
- diff = d - exp, computed signed in DATA_PATH_BITWIDTH+1 bits.
- mismatch = |diff| > err_thresh, compared unsigned; err_thresh is sampled in stage 2.
REQ-017 Latency from in_valid to the counter update and FIFO push is exactly 2 cycles; back-to-back samples are supported at one per cycle.
REQ-018 sample_cnt increments once per stage-2 sample and saturates at 16'hFFFF.
REQ-019 mismatch_cnt increments once per stage-2 mismatch and saturates at 16'hFFFF.
REQ-020 Each mismatch pushes {a,b,d} into the FIFO when it is not full; when it is full, the record is dropped and overflow is set.
REQ-021 out_valid is 1 exactly when the FIFO is non-empty, and the out_* fields show the head record.
REQ-022 A pop occurs on a cycle with out_valid=1 and out_ready=1.
REQ-023 A simultaneous push and pop while full succeeds, with no drop and no overflow.
REQ-024 A simultaneous push and pop while empty leaves the new record visible on the next cycle.
REQ-025 FIFO read and write pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-026 clr=1 in a cycle has the following effects:
- counters, FIFO and overflow are cleared on the next edge;
- in-flight stage-1 and stage-2 samples are discarded;
- clr takes priority over a simultaneous push or pop.

Reset
REQ-027 When rst=0, all state clears immediately regardless of clk:
- pipeline valid bits, pointers, counters and overflow go to 0;
- out_valid=0; out_a, out_b and out_d are 0.
REQ-028 Reset asserted mid-operation discards all in-flight samples and FIFO contents.
REQ-029 After rst deasserts, the first sample accepted is the one presented with in_valid=1 on the first rising edge at which rst=1.

Configuration
REQ-030 Macro COLLECT_MAX_ERR_EN, when defined, adds output max_err (DATA_PATH_BITWIDTH bits).
- max_err holds the largest |diff| seen since reset or clr, matched or not.
- It is updated in stage 2 and resets to 0.
REQ-031 Without COLLECT_MAX_ERR_EN, the max_err port and its logic are absent, and all other behaviour is identical.

Verification
REQ-032 Exact match:
- stimulus: OP=32, thresh=0, a=3, b=-5, d=-15, one sample;
- response: 2 cycles later sample_cnt=1, mismatch_cnt=0, out_valid=0.
REQ-033 Tolerance boundary:
- stimulus: thresh=2, a=7, b=7, d=51, then d=52;
- response: |diff|=2 gives no mismatch; |diff|=3 gives mismatch_cnt=1 and the FIFO head {7,7,52}.
REQ-034 OP masking:
- stimulus: OP=26, a=32'hFC00_0001, b=2, d=2;
- response: upper bits are ignored, exp=2, no mismatch.
REQ-035 FIFO full and overflow:
- stimulus: FIFO_DEPTH=8, out_ready=0, 9 back-to-back mismatches;
- response: 8 records are held, overflow=1, mismatch_cnt=9.
- Then out_ready=1: exactly 8 pops occur in order, then out_valid=0.
REQ-036 Simultaneous events and reset:
- stimulus: with the FIFO full, push and pop in the same cycle;
- response: the count stays at 8 and overflow stays 0.
- Then assert rst=0 mid-stream: all outputs read 0 immediately.
REQ-037 Max error (only with COLLECT_MAX_ERR_EN):
- stimulus: errors of 5, 1 and 9;
- response: max_err=9; clr returns max_err to 0.
